// File: rtl/init_mem_if.sv
// Bus bundle for init_mem: write port, clear request, multi-port reads, status.
interface init_mem_if #(
  parameter int DATA    = 8,
  parameter int ADDR    = 8,
  parameter int NUMREAD = 2
) ();
  logic                             wr_en;
  logic [ADDR-1:0]                  wr_addr;
  logic [DATA-1:0]                  wr_data;
  logic                             clear;
  logic [NUMREAD-1:0]               rd_en;
  logic [NUMREAD-1:0][ADDR-1:0]     rd_addr;
  logic [NUMREAD-1:0][DATA-1:0]     rd_data;
  logic [NUMREAD-1:0]               rd_valid;
  logic                             busy;

  // Requester side drives requests and observes results.
  modport master (
    output wr_en, wr_addr, wr_data, clear, rd_en, rd_addr,
    input  rd_data, rd_valid, busy
  );

  // Memory side.
  modport slave (
    input  wr_en, wr_addr, wr_data, clear, rd_en, rd_addr,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/init_mem.sv
// Self-initialising RAM: after reset (or on a clear pulse) a sweep writes
// INIT_VAL to every word, one per cycle; user traffic is ignored meanwhile.
// One write port and NUMREAD independent registered read ports.
module init_mem #(
  parameter int              DATA        = 8,
  parameter int              ADDR        = 8,
  parameter int              NUMREAD     = 2,
  parameter bit              WRITE_FIRST = 1'b1,
  parameter logic [DATA-1:0] INIT_VAL    = '0
) (
  input  logic       clk,
  input  logic       rst,
  init_mem_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR;

  typedef enum logic {SWEEP = 1'b0, IDLE = 1'b1} state_t;

  state_t                       state;
  logic [ADDR-1:0]              sweep_cnt;
  logic                         busy_q;
  logic [DATA-1:0]              mem [DEPTH];
  logic [NUMREAD-1:0][DATA-1:0] rd_word;
  logic [NUMREAD-1:0][DATA-1:0] rd_data_q;
  logic [NUMREAD-1:0]           rd_valid_q;

  // Sweep control: walk every address once, then idle until a clear request.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, matching real hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SWEEP;
      sweep_cnt <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state)
        SWEEP: begin
          sweep_cnt <= sweep_cnt + 1'b1;  // wraps to 0 after the last word
          if (sweep_cnt == '1) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        IDLE: begin
          if (bus.clear) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          state  <= SWEEP;
          busy_q <= 1'b1;
        end
      endcase
    end
  end

  // Array write: sweep has priority and locks out user writes.
  // NOTE: the array deliberately has no reset; its contents are defined by
  // the sweep, which lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == SWEEP) begin
      mem[sweep_cnt] <= INIT_VAL;
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Per-port read word, with optional bypass of a same-address write.
  // NOTE: defaults assigned first so no path leaves rd_word unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUMREAD; i++) begin
      rd_word[i] = mem[bus.rd_addr[i]];
      if (WRITE_FIRST && bus.wr_en && (bus.wr_addr == bus.rd_addr[i])) begin
        rd_word[i] = bus.wr_data;
      end
    end
  end

  // Registered read ports: load and flag on a request while idle, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      for (int i = 0; i < NUMREAD; i++) begin
        if (state == IDLE && bus.rd_en[i]) begin
          rd_data_q[i]  <= rd_word[i];
          rd_valid_q[i] <= 1'b1;
        end else begin
          rd_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_init_mem.sv
// Bench for init_mem: two instances (write-first and read-first) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_init_mem;
  localparam int              DATA  = 8;
  localparam int              ADDR  = 4;
  localparam int              NR    = 2;
  localparam int              DEPTH = 16;
  localparam logic [DATA-1:0] INIT  = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic                     wr_en   = 1'b0;
  logic [ADDR-1:0]          wr_addr = '0;
  logic [DATA-1:0]          wr_data = '0;
  logic                     clear   = 1'b0;
  logic [NR-1:0]            rd_en   = '0;
  logic [NR-1:0][ADDR-1:0]  rd_addr = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  init_mem_if #(.DATA(DATA), .ADDR(ADDR), .NUMREAD(NR)) bus_wf ();
  init_mem_if #(.DATA(DATA), .ADDR(ADDR), .NUMREAD(NR)) bus_rf ();

  assign bus_wf.wr_en   = wr_en;
  assign bus_wf.wr_addr = wr_addr;
  assign bus_wf.wr_data = wr_data;
  assign bus_wf.clear   = clear;
  assign bus_wf.rd_en   = rd_en;
  assign bus_wf.rd_addr = rd_addr;
  assign bus_rf.wr_en   = wr_en;
  assign bus_rf.wr_addr = wr_addr;
  assign bus_rf.wr_data = wr_data;
  assign bus_rf.clear   = clear;
  assign bus_rf.rd_en   = rd_en;
  assign bus_rf.rd_addr = rd_addr;

  init_mem #(.DATA(DATA), .ADDR(ADDR), .NUMREAD(NR), .WRITE_FIRST(1'b1),
             .INIT_VAL(INIT)) dut_wf (.clk(clk), .rst(rst), .bus(bus_wf));
  init_mem #(.DATA(DATA), .ADDR(ADDR), .NUMREAD(NR), .WRITE_FIRST(1'b0),
             .INIT_VAL(INIT)) dut_rf (.clk(clk), .rst(rst), .bus(bus_rf));

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sweep is "words still to initialise"; reads see the array before the
  // cycle's write, except the write-first flavour which sees the new data.
  logic [DATA-1:0] m_mem [DEPTH];
  int              m_left  = DEPTH;
  logic [NR-1:0]   m_valid = '0;
  logic [DATA-1:0] m_wf [NR] = '{default: '0};
  logic [DATA-1:0] m_rf [NR] = '{default: '0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left  = DEPTH;
      m_valid = '0;
      for (int i = 0; i < NR; i++) begin
        m_wf[i] = '0;
        m_rf[i] = '0;
      end
    end else if (m_left > 0) begin
      m_mem[DEPTH - m_left] = INIT;
      m_left  = m_left - 1;
      m_valid = '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        m_valid[i] = rd_en[i];
        if (rd_en[i]) begin
          m_rf[i] = m_mem[rd_addr[i]];
          m_wf[i] = (wr_en && wr_addr == rd_addr[i]) ? wr_data : m_mem[rd_addr[i]];
        end
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
      if (clear) m_left = DEPTH;
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    check("busy_wf",  {31'd0, bus_wf.busy}, {31'd0, m_left > 0});
    check("busy_rf",  {31'd0, bus_rf.busy}, {31'd0, m_left > 0});
    check("valid_wf", {30'd0, bus_wf.rd_valid}, {30'd0, m_valid});
    check("valid_rf", {30'd0, bus_rf.rd_valid}, {30'd0, m_valid});
    for (int i = 0; i < NR; i++) begin
      check($sformatf("rd_data_wf[%0d]", i), {24'd0, bus_wf.rd_data[i]}, {24'd0, m_wf[i]});
      check($sformatf("rd_data_rf[%0d]", i), {24'd0, bus_rf.rd_data[i]}, {24'd0, m_rf[i]});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    wr_en = 1'b0;
    clear = 1'b0;
    rd_en = '0;
  endtask

  // Counts busy cycles while hammering writes/reads (which must be ignored);
  // optionally pulses clear when the sweep is at word clear_at.
  task automatic run_sweep(input int clear_at, output int n);
    n = 0;
    while (bus_wf.busy && n < 40) begin
      clear      = (n == clear_at);
      wr_en      = 1'b1;
      wr_addr    = 4'(n);
      wr_data    = 8'(8'h5A ^ n);
      rd_en      = 2'b11;
      rd_addr[0] = 4'(n);
      rd_addr[1] = 4'(15 - n);
      tick();
      n++;
    end
    quiet();
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      rd_en      = 2'b11;
      rd_addr[0] = 4'(a);
      rd_addr[1] = 4'(DEPTH - 1 - a);
      tick();
      check("read_all_valid", {30'd0, bus_wf.rd_valid}, 32'h3);
      check("read_all_data",  {24'd0, bus_wf.rd_data[0]}, 32'hA5);
    end
    quiet();
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    #2 rst = 1'b1;
    #1;
    check("reset_busy",  {31'd0, bus_wf.busy}, 32'h1);
    check("reset_valid", {30'd0, bus_wf.rd_valid}, 32'h0);
    check("reset_data",  {16'd0, bus_wf.rd_data}, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Power-up sweep then every word reads INIT.
    run_sweep(-1, n);
    check("init_sweep_len", n, 16);
    read_all();

    // Write then dual-port read of the same address.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0; rd_en = 2'b11; rd_addr[0] = 4'd5; rd_addr[1] = 4'd5;
    tick();
    check("dual_valid", {30'd0, bus_wf.rd_valid}, 32'h3);
    check("dual_p0",    {24'd0, bus_wf.rd_data[0]}, 32'h3C);
    check("dual_p1",    {24'd0, bus_wf.rd_data[1]}, 32'h3C);
    quiet();
    tick();
    check("valid_drops", {30'd0, bus_wf.rd_valid}, 32'h0);
    check("data_held",   {24'd0, bus_wf.rd_data[0]}, 32'h3C);

    // Same-cycle read/write collision; port 1 reads an unrelated address.
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h11;
    tick();
    wr_data = 8'h22; rd_en = 2'b11; rd_addr[0] = 4'd7; rd_addr[1] = 4'd5;
    tick();
    check("collide_wf",   {24'd0, bus_wf.rd_data[0]}, 32'h22);
    check("collide_rf",   {24'd0, bus_rf.rd_data[0]}, 32'h11);
    check("no_interact",  {24'd0, bus_rf.rd_data[1]}, 32'h3C);
    wr_en = 1'b0; rd_en = 2'b01;
    tick();
    check("after_wf", {24'd0, bus_wf.rd_data[0]}, 32'h22);
    check("after_rf", {24'd0, bus_rf.rd_data[0]}, 32'h22);
    quiet();
    tick();

    // Clear sweep with user traffic locked out.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    run_sweep(-1, n);
    check("clear_sweep_len", n, 16);
    read_all();

    // Clear re-pulsed mid-sweep must not extend it.
    clear = 1'b1;
    tick();
    run_sweep(3, n);
    check("reclear_sweep_len", n, 16);
    read_all();

    // Reset at sweep word 9 abandons it and restarts from word 0.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    check("midrst_busy",  {31'd0, bus_wf.busy}, 32'h1);
    check("midrst_valid", {30'd0, bus_wf.rd_valid}, 32'h0);
    check("midrst_data",  {16'd0, bus_wf.rd_data}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    run_sweep(-1, n);
    check("post_rst_sweep_len", n, 16);
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/init_mem.md
INIT_MEM -- requirements
Module: init_mem

Interface
REQ-001: Parameter DATA, default 8, SHALL set the width of each memory word in bits.
REQ-002: Parameter ADDR, default 8, SHALL set the address width; depth is 2**ADDR words.
REQ-003: Parameter NUMREAD, default 2, SHALL set the number of independent read ports (min 1).
REQ-004: Parameter WRITE_FIRST, default 1, SHALL select same-address read-during-write mode: 1 = new data, 0 = old data.
REQ-005: Parameter INIT_VAL, default 0, SHALL set the DATA-bit value written to every word by a clear sweep.
REQ-006: clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007: rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-008: wr_en  input  1  SHALL request a write this cycle.
REQ-009: wr_addr  input  ADDR  SHALL be the write address.
REQ-010: wr_data  input  DATA  SHALL be the write data.
REQ-011: clear  input  1  SHALL request a clear sweep (single-cycle pulse sufficient).
REQ-012: rd_en  input  NUMREAD  SHALL hold one read request per port.
REQ-013: rd_addr  input  NUMREAD x ADDR  SHALL hold one read address per port.
REQ-014: rd_data  output  NUMREAD x DATA  SHALL hold registered read data per port.
REQ-015: rd_valid  output  NUMREAD  SHALL flag per-port rd_data updated by the previous cycle's read.
REQ-016: busy  output  1  SHALL be high while a clear sweep is in progress.

Function
REQ-017: FSM SHALL have two states: SWEEP and IDLE.
REQ-018: In SWEEP: one word/cycle, INIT_VAL written to sweep-counter address, counter +1 per cycle from 0.
REQ-019: Sweep SHALL take exactly 2**ADDR cycles; after writing address 2**ADDR-1: -> IDLE next edge, counter wraps to 0.
REQ-020: busy SHALL equal (state == SWEEP), driven from a register, no combinational path from inputs.
REQ-021: In IDLE, clear=1 at a rising edge SHALL -> SWEEP, counter 0; first sweep write next cycle.
REQ-022: clear while in SWEEP SHALL be ignored; running sweep not restarted or extended.
REQ-023: In SWEEP, wr_en and rd_en SHALL be ignored: no user write, rd_valid 0, rd_data held.
REQ-024: In IDLE, wr_en=1 SHALL write wr_data to wr_addr at the rising edge.
REQ-025: In IDLE, rd_en[i]=1 SHALL load rd_data[i] with word at rd_addr[i] and set rd_valid[i]=1 for the next cycle; latency 1.
REQ-026: rd_en[i]=0 in IDLE SHALL clear rd_valid[i] next cycle and hold rd_data[i]; outputs never tri-stated.
REQ-027: Ports SHALL be fully independent; any ports may read the same address in one cycle with identical results.
REQ-028: Same-cycle write and read[i] to one address: WRITE_FIRST=1 -> rd_data[i]=wr_data; WRITE_FIRST=0 -> prior contents.
REQ-029: Read/write to different addresses in one cycle SHALL not interact.
REQ-030: Addresses SHALL be ADDR bits wide, so every address is in range; no out-of-range case.

Reset
REQ-031: rst=1 SHALL asynchronously force state=SWEEP, counter=0, busy=1, rd_valid=0, rd_data=0.
REQ-032: Memory array SHALL have no reset; contents SHALL be defined by the sweep after rst deasserts.
REQ-033: First rising edge with rst=0 SHALL write INIT_VAL to address 0.
REQ-034: rst asserted mid-sweep or mid-read SHALL abandon that operation; sweep restarts at address 0 after release.

Verification
REQ-035: ADDR=4, INIT_VAL=8'hA5: release rst -> busy high exactly 16 cycles, then low; read all 16 addresses -> each 8'hA5, rd_valid 1 cycle after rd_en.
REQ-036: IDLE: write 8'h3C @5, next cycle rd_en[0]=rd_en[1]=1 @5 -> both rd_data=8'h3C, rd_valid=2'b11 one cycle later.
REQ-037: Mem[7]=8'h11; same cycle write 8'h22 @7 and read @7 -> WRITE_FIRST=1: 8'h22; WRITE_FIRST=0: 8'h11; next read 8'h22.
REQ-038: IDLE, clear pulse -> busy next cycle for 16 cycles; wr_en/rd_en during sweep -> rd_valid 0, no writes land, all words = INIT_VAL after.
REQ-039: rst asserted at sweep address 9 -> immediate busy=1, rd_valid=0, rd_data=0; after release full 16-cycle sweep from address 0.
REQ-040: clear pulsed at sweep address 3 -> sweep ends at original time (16 cycles total), no restart.
